dispense_ctrl: RTL and testbench
================================

DISPENSE_CTRL -- requirements
Module: dispense_ctrl

Interface
REQ-001 Parameter HEAT_CYCLES, default 8: cycles EF stays high; legal range 1..255.
REQ-002 Parameter POUR_A, default 4: EG cycles for drink A; legal range 1..255.
REQ-003 Parameter POUR_B, default 6: EG cycles for drink B; legal range 1..255.
REQ-004 Parameter POUR_C, default 8: EG cycles for drink C; legal range 1..255.
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 EES  in  1  primary machine handoff state; drink ready to transfer.
REQ-008 EA  in  1  primary machine idle state.
REQ-009 sel  in  3  drink select {A,B,C}, one-hot; sel[2]=A, sel[1]=B, sel[0]=C.
REQ-010 cup  in  1  cup-present sensor, 1 = cup in place.
REQ-011 EF  out  1  heat stage active.
REQ-012 EG  out  1  pour stage active.
REQ-013 EH  out  1  hold stage: drink served, waiting for cup removal.
REQ-014 err  out  1  fault state active.
REQ-015 done  out  1  one-cycle pulse on completed service.

Function
REQ-016 FSM states IDLE, HEAT, POUR, HOLD, ERR; EF/EG/EH/err each high exactly while in HEAT/POUR/HOLD/ERR; all outputs registered.
REQ-017 IDLE: EES=1, cup=1, sel one-hot -> latch sel, load timer with HEAT_CYCLES, go HEAT next edge.
REQ-018 IDLE: EES=1, cup=1, sel not one-hot (000, 111, any two bits) -> ERR next edge.
REQ-019 IDLE: EES=1, cup=0 -> stay IDLE, no error.
REQ-020 HEAT: lasts exactly HEAT_CYCLES cycles, then POUR with timer loaded from latched drink's POUR_x.
REQ-021 POUR: lasts exactly POUR_x cycles, then HOLD.
REQ-022 cup=0 in any cycle of HEAT or POUR -> ERR next edge; takes priority over timer expiry in the same cycle.
REQ-023 HOLD: remain until cup=0; then IDLE next edge with done=1 for that single cycle.
REQ-024 ERR: remain until EA=1 and EES=0 in the same cycle, then IDLE; done never asserted from ERR.
REQ-025 sel and EES changes outside IDLE ignored; latched drink is used for the whole service.
REQ-026 Timer 8-bit down-counter; stage ends on the cycle count reaches 1; no wrap-around, never decrements below 0.
REQ-027 Total EF+EG high time for drink B at defaults = 8+6 = 14 cycles, gap-free.

Reset
REQ-028 rst_n=0 at a rising edge -> IDLE, timer=0, latched sel=000, EF=EG=EH=err=done=0 from the next cycle.
REQ-029 Reset mid-service (any state) aborts without done pulse; resumes only on a fresh IDLE start condition.

Structure
REQ-030 Shared package holds state enum (IDLE, HEAT, POUR, HOLD, ERR), 8-bit timer width constant, default duration constants.
REQ-031 One sub-module cycle_timer: load, load value, decrement enable, last-cycle flag; instantiated once.

Verification
REQ-032 Defaults, sel=010, cup=1, EES pulse in IDLE -> EF high 8 cycles, EG high 6 cycles, EH high until cup=0, then done one cycle, IDLE.
REQ-033 sel=110 with EES=1, cup=1 -> err=1 next cycle; holds while EA=0; EA=1, EES=0 -> IDLE, done=0.
REQ-034 sel=100 start, cup=0 on 3rd POUR cycle -> err=1 next cycle, EG=0, no done.
REQ-035 EES=1, cup=0, sel=001 -> outputs all 0 indefinitely; raise cup -> HEAT next cycle.
REQ-036 rst_n=0 during HEAT cycle 5 -> all outputs 0 next cycle; EES held high with cup=1 restarts full 8-cycle HEAT.
REQ-037 sel changed 001->100 during HEAT with sel=001 latched -> POUR lasts POUR_C = 8 cycles.

Source files
------------

// File: rtl/dispense_ctrl_pkg.sv
// Shared definitions for the drink dispenser controller.
//   - state_t        : controller FSM states
//   - TIMER_W        : width of the stage down-counter
//   - DEF_*          : default stage durations in clock cycles
//   - is_one_hot3()  : true when exactly one of three select bits is set
package dispense_ctrl_pkg;

   localparam int TIMER_W         = 8;
   localparam int DEF_HEAT_CYCLES = 8;
   localparam int DEF_POUR_A      = 4;
   localparam int DEF_POUR_B      = 6;
   localparam int DEF_POUR_C      = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HEAT = 3'd1,
      POUR = 3'd2,
      HOLD = 3'd3,
      ERR  = 3'd4
   } state_t;

   function automatic logic is_one_hot3(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

endpackage

// File: rtl/dispense_ctrl_cycle_timer.sv
// Stage duration down-counter.
//   clk, rst_n   : clock, synchronous active-low reset (count clears to 0)
//   load_i       : load load_val_i this cycle (takes priority over decrement)
//   load_val_i   : stage length in cycles
//   dec_i        : decrement enable; the count never goes below 0
//   last_o       : high while the count is 1, i.e. the final cycle of a stage
module cycle_timer
   import dispense_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               last_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/dispense_ctrl.sv
// Drink dispenser sequencer: heat, pour for the latched drink's duration,
// hold until the cup is removed, with a fault state for bad selections or
// cup loss mid-service.
//   clk, rst_n   : clock, synchronous active-low reset
//   EES          : primary machine handoff (drink ready to transfer)
//   EA           : primary machine idle
//   sel[2:0]     : one-hot drink select, [2]=A, [1]=B, [0]=C
//   cup          : cup-present sensor
//   EF/EG/EH/err : high while in HEAT/POUR/HOLD/ERR (registered)
//   done         : one-cycle pulse when a served cup is removed
//   dbg_state_o  : current FSM state encoding
//
// Handshake: a service starts in IDLE on the first cycle with EES=1 and
// cup=1; EES and sel are ignored everywhere else. ERR is left only on a
// cycle with EA=1 and EES=0.
module dispense_ctrl
   import dispense_ctrl_pkg::*;
#(
   parameter int unsigned HEAT_CYCLES = DEF_HEAT_CYCLES,
   parameter int unsigned POUR_A      = DEF_POUR_A,
   parameter int unsigned POUR_B      = DEF_POUR_B,
   parameter int unsigned POUR_C      = DEF_POUR_C
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EES,
   input  logic       EA,
   input  logic [2:0] sel,
   input  logic       cup,
   output logic       EF,
   output logic       EG,
   output logic       EH,
   output logic       err,
   output logic       done,
   output logic [2:0] dbg_state_o
);

   localparam logic [TIMER_W-1:0] HEAT_LD = TIMER_W'(HEAT_CYCLES);
   localparam logic [TIMER_W-1:0] POUR_A_LD = TIMER_W'(POUR_A);
   localparam logic [TIMER_W-1:0] POUR_B_LD = TIMER_W'(POUR_B);
   localparam logic [TIMER_W-1:0] POUR_C_LD = TIMER_W'(POUR_C);

   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic               done_q, done_d;
   logic               ef_q, eg_q, eh_q, err_q;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_dec;
   logic               tmr_last;
   logic [TIMER_W-1:0] pour_len;

   cycle_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .last_o     (tmr_last)
   );

   // sel_q is always one-hot once a service has started.
   always_comb begin
      case (sel_q)
         3'b100:  pour_len = POUR_A_LD;
         3'b010:  pour_len = POUR_B_LD;
         default: pour_len = POUR_C_LD;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (EES && cup) begin
               if (is_one_hot3(sel)) begin
                  sel_d    = sel;
                  tmr_load = 1'b1;
                  tmr_val  = HEAT_LD;
                  state_d  = HEAT;
               end else begin
                  state_d = ERR;
               end
            end
         end
         // Cup loss is checked before timer expiry so it wins on the last cycle.
         HEAT: begin
            if (!cup) begin
               state_d = ERR;
            end else if (tmr_last) begin
               tmr_load = 1'b1;
               tmr_val  = pour_len;
               state_d  = POUR;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         POUR: begin
            if (!cup) begin
               state_d = ERR;
            end else if (tmr_last) begin
               state_d = HOLD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         HOLD: begin
            if (!cup) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         ERR: begin
            if (EA && !EES) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 3'b000;
         done_q  <= 1'b0;
         ef_q    <= 1'b0;
         eg_q    <= 1'b0;
         eh_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         ef_q    <= (state_d == HEAT);
         eg_q    <= (state_d == POUR);
         eh_q    <= (state_d == HOLD);
         err_q   <= (state_d == ERR);
      end
   end

   assign EF          = ef_q;
   assign EG          = eg_q;
   assign EH          = eh_q;
   assign err         = err_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dispense_ctrl.sv
// Bench for dispense_ctrl at default durations.
module tb_dispense_ctrl;

   localparam int H  = 8;
   localparam int PA = 4;
   localparam int PB = 6;
   localparam int PC = 8;

   logic       clk;
   logic       rst_n;
   logic       EES;
   logic       EA;
   logic [2:0] sel;
   logic       cup;
   logic       EF, EG, EH, err, done;
   logic [2:0] dbg_state;

   int n_tests;
   int n_fail;

   dispense_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .EES         (EES),
      .EA          (EA),
      .sel         (sel),
      .cup         (cup),
      .EF          (EF),
      .EG          (EG),
      .EH          (EH),
      .err         (err),
      .done        (done),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pour_of(input logic [2:0] s);
      case (s)
         3'b100:  return PA;
         3'b010:  return PB;
         default: return PC;
      endcase
   endfunction

   // Expected {EF,EG,EH,err,done} for sample j after the start edge.
   // The cup is first seen absent at edge d (d >= 1): while heating or
   // pouring that means a fault, otherwise it ends the hold.
   function automatic logic [4:0] exp_vec(input int j, input int p, input int d);
      if (d <= H + p) begin
         if (j >= d) return 5'b00010;
      end else begin
         if (j == d) return 5'b00001;
         if (j > d)  return 5'b00000;
      end
      if (j < H)     return 5'b10000;
      if (j < H + p) return 5'b01000;
      return 5'b00100;
   endfunction

   function automatic logic [4:0] obs();
      return {EF, EG, EH, err, done};
   endfunction

   // ---------------- scenario tasks ----------------
   // Starts from IDLE, away from a clock edge.
   task automatic run_service(input logic [2:0] s, input int d, input bit rand_noise,
                              input logic [2:0] alt_sel, input string name);
      int p;
      int last;
      logic [4:0] e;
      p    = pour_of(s);
      last = (d <= H + p) ? d + 3 : d + 1;
      EES = 1'b1; cup = 1'b1; sel = s; EA = 1'b0;
      for (int j = 0; j <= last; j++) begin
         @(posedge clk); #1;
         cup = (j + 1 >= d) ? 1'b0 : 1'b1;
         EA  = 1'b0;
         if (rand_noise) begin
            EES = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
         end else begin
            EES = 1'b1;
            sel = alt_sel;
         end
         @(negedge clk);
         e = exp_vec(j, p, d);
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL %s sample %0d: got %b expected %b (sel=%b d=%0d)",
                     name, j, obs(), e, s, d);
         end
      end
      if (d <= H + p) begin
         // EA alone is not enough to leave the fault state.
         EA = 1'b1; EES = 1'b1;
         @(negedge clk);
         n_tests++;
         if (obs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL %s err_hold_ees: got %b expected 00010", name, obs());
         end
         EES = 1'b0;
         @(negedge clk);
         n_tests++;
         if (obs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s err_exit: got %b expected 00000", name, obs());
         end
         EA = 1'b0;
      end
      EES = 1'b0; cup = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; EES = 1'b0; EA = 1'b0; cup = 1'b0; sel = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (obs() !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 00000", obs());
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs() !== 5'b00000) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b expected 00000", obs());
      end
   endtask

   task automatic test_invalid_sel();
      logic [2:0] bad [5];
      bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      for (int k = 0; k < 5; k++) begin
         EES = 1'b1; cup = 1'b1; sel = bad[k]; EA = 1'b0;
         @(negedge clk);
         n_tests++;
         if (obs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL invalid_sel %b enter: got %b expected 00010", bad[k], obs());
         end
         EES = 1'b0;
         repeat (2) @(negedge clk);
         n_tests++;
         if (obs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL invalid_sel %b hold: got %b expected 00010", bad[k], obs());
         end
         EA = 1'b1;
         @(negedge clk);
         n_tests++;
         if (obs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL invalid_sel %b exit: got %b expected 00000", bad[k], obs());
         end
         EA = 1'b0;
      end
   endtask

   task automatic test_cup_absent();
      EES = 1'b1; cup = 1'b0; sel = 3'b001; EA = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL cup_absent cycle %0d: got %b expected 00000", k, obs());
         end
      end
      cup = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs() !== 5'b10000) begin
         n_fail++;
         $display("FAIL cup_raised_heat: got %b expected 10000", obs());
      end
      cup = 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs() !== 5'b00010) begin
         n_fail++;
         $display("FAIL cup_lost_heat: got %b expected 00010", obs());
      end
      EES = 1'b0; EA = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs() !== 5'b00000) begin
         n_fail++;
         $display("FAIL cup_lost_exit: got %b expected 00000", obs());
      end
      EA = 1'b0;
   endtask

   task automatic test_reset_mid();
      EES = 1'b1; cup = 1'b1; sel = 3'b010; EA = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         n_tests++;
         if (obs() !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_mid heat %0d: got %b expected 10000", j, obs());
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs() !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_mid outputs: got %b expected 00000", obs());
      end
      rst_n = 1'b1;
      run_service(3'b010, H + PB + 3, 1'b0, 3'b010, "reset_restart");
   endtask

   task automatic test_random();
      logic [2:0] drinks [3];
      logic [2:0] s;
      int d;
      drinks = '{3'b100, 3'b010, 3'b001};
      for (int k = 0; k < 25; k++) begin
         s = drinks[$urandom_range(0, 2)];
         d = $urandom_range(1, H + pour_of(s) + 6);
         run_service(s, d, 1'b1, 3'b000, "random");
         @(negedge clk);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      // Drink B full service, cup removed a few cycles into hold.
      run_service(3'b010, H + PB + 5, 1'b0, 3'b010, "drink_b");
      test_invalid_sel();
      // Drink A, cup pulled during the third pour cycle.
      run_service(3'b100, H + 3, 1'b0, 3'b100, "pour_cup_loss");
      // Cup loss on the final pour cycle beats the stage ending.
      run_service(3'b001, H + PC, 1'b0, 3'b001, "cup_loss_last_pour");
      // Cup loss on the final heat cycle.
      run_service(3'b100, H, 1'b0, 3'b100, "cup_loss_last_heat");
      // Release on the very first hold cycle.
      run_service(3'b100, H + PA + 1, 1'b0, 3'b100, "first_hold_release");
      test_cup_absent();
      test_reset_mid();
      // Drink C latched; sel switched to A afterwards must not change pour.
      run_service(3'b001, H + PC + 4, 1'b0, 3'b100, "sel_change_ignored");
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
